fixed_act_requant: RTL

- Downstream neighbour of the LUT-based fixed-point activation stages (fixed_elu and siblings).
- Converts each activation lane from the activation's fixed-point format to the next layer's format: round-half-up, then signed saturation.
- Two-stage valid/ready pipeline, full throughput.
- Generates a tensor-boundary "last" flag and a saturation-event counter for debug.

---
 rtl/fixed_act_requant_pkg.sv | 30 +++
 rtl/fixed_act_requant_if.sv | 13 +
 rtl/fixed_act_requant_lane.sv | 41 ++++
 rtl/fixed_act_requant.sv | 114 +++++++++++
 4 files changed

// File: rtl/fixed_act_requant_pkg.sv
// fixed_act_pkg: shared width/shift/range helpers for the activation requantiser
package fixed_act_pkg;

    function automatic int abs_i(input int v);
        return v < 0 ? -v : v;
    endfunction

    // Positive shift means dropping fractional bits (round then shift right).
    function automatic int shift_amt(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    // One spare bit above the shifted input keeps the rounding add from overflowing.
    function automatic int mid_width(input int in_w, input int s);
        return in_w + abs_i(s) + 1;
    endfunction

    function automatic longint out_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint out_min(input int w);
        return -out_max(w) - 1;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/fixed_act_requant_if.sv
// fixed_act_requant_if: valid/ready beat bus carrying N packed lanes plus a tensor-end flag
interface fixed_act_requant_if #(
    parameter int N = 1,
    parameter int W = 8
);
    logic [N*W-1:0] data;
    logic           valid;
    logic           ready;
    logic           last;

    modport master(output data, valid, last, input ready);
    modport slave(input data, valid, output ready);
endinterface

// File: rtl/fixed_act_requant_lane.sv
// fixed_requant_lane: per-lane round/shift into a wide value, and saturation of a registered wide value
module fixed_requant_lane
    import fixed_act_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int IN_FRAC = 4,
    parameter int OUT_W = 8,
    parameter int OUT_FRAC = 3,
    localparam int S = shift_amt(IN_FRAC, OUT_FRAC),
    localparam int A = abs_i(S),
    localparam int MID_W = mid_width(IN_W, S)
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [MID_W-1:0] rnd_o,
    input  logic signed [MID_W-1:0] mid_i,
    output logic        [OUT_W-1:0] dout_o,
    output logic                    sat_o
);
    localparam int CW = MID_W > OUT_W ? MID_W : OUT_W;
    localparam logic signed [MID_W-1:0] HALF = S > 0 ? MID_W'(1) << (S > 0 ? S - 1 : 0) : '0;
    localparam logic signed [CW-1:0] OMAX = CW'(out_max(OUT_W));
    localparam logic signed [CW-1:0] OMIN = CW'(out_min(OUT_W));

    logic signed [MID_W-1:0] ext;
    logic signed [MID_W-1:0] sum;
    logic signed [CW-1:0]    wide;

    // Right shifts round half toward +inf; left shifts and pass-through are exact.
    always_comb begin
        ext = MID_W'(din_i);
        sum = ext + HALF;
        rnd_o = S > 0 ? sum >>> A : S < 0 ? ext <<< A : ext;
    end

    // Clamp into the signed output range and flag lanes that needed clamping.
    always_comb begin
        wide = CW'(mid_i);
        sat_o = wide > OMAX || wide < OMIN;
        dout_o = wide > OMAX ? OMAX[OUT_W-1:0] : wide < OMIN ? OMIN[OUT_W-1:0] : wide[OUT_W-1:0];
    end
endmodule

// File: rtl/fixed_act_requant.sv
// fixed_act_requant: two-stage valid/ready requantiser with tensor-end tagging and a saturation counter
module fixed_act_requant
    import fixed_act_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 8,
    parameter int DATA_IN_0_PRECISION_1 = 4,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
    parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    fixed_act_requant_if.slave       data_in_0,
    fixed_act_requant_if.master      data_out_0,
    input  logic                     sat_count_clr,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);
    localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int IN_W = DATA_IN_0_PRECISION_0;
    localparam int OUT_W = DATA_OUT_0_PRECISION_0;
    localparam int S = shift_amt(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);
    localparam int MID_W = mid_width(IN_W, S);
    localparam int DEPTH = ceil_div(DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1, N);
    localparam int BW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH - 1);

    logic signed [MID_W-1:0] rnd [N];
    logic signed [MID_W-1:0] s1_q [N];
    logic [N*OUT_W-1:0]      dout;
    logic [N*OUT_W-1:0]      data_q;
    logic [N-1:0]            sat;
    logic [N-1:0]            sat_q;
    logic                    s1_valid_q;
    logic                    s2_valid_q;
    logic                    last_q;
    logic [BW-1:0]           beat_q;
    logic [SAT_CNT_WIDTH-1:0] sat_count_q;
    logic [SAT_CNT_WIDTH-1:0] sat_count_d;
    logic [SAT_CNT_WIDTH:0]   sum;
    logic                    s1_adv;
    logic                    s2_adv;
    logic                    s2_load;

    assign s2_adv = !s2_valid_q || data_out_0.ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign s2_load = s1_valid_q && s2_adv;
    assign data_in_0.ready = s1_adv;
    assign data_out_0.valid = s2_valid_q;
    assign data_out_0.data = data_q;
    assign data_out_0.last = last_q;
    assign sat_count = sat_count_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_requant_lane #(
            .IN_W(IN_W),
            .IN_FRAC(DATA_IN_0_PRECISION_1),
            .OUT_W(OUT_W),
            .OUT_FRAC(DATA_OUT_0_PRECISION_1)
        ) u_lane (
            .din_i(data_in_0.data[i*IN_W +: IN_W]),
            .rnd_o(rnd[i]),
            .mid_i(s1_q[i]),
            .dout_o(dout[i*OUT_W +: OUT_W]),
            .sat_o(sat[i])
        );
    end

    // Stage 1 holds the rounded/shifted wide lanes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_q <= '{default: '0};
        end else if (s1_adv) begin
            s1_valid_q <= data_in_0.valid;
            if (data_in_0.valid) s1_q <= rnd;
        end
    end

    // Stage 2 holds saturated lanes, their sat flags and the tensor-end tag taken from the beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            data_q <= '0;
            sat_q <= '0;
            last_q <= 1'b0;
            beat_q <= '0;
        end else begin
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                data_q <= dout;
                sat_q <= sat;
                last_q <= beat_q == LAST_BEAT;
                beat_q <= beat_q == LAST_BEAT ? '0 : beat_q + 1'b1;
            end
        end
    end

    // Clear wins; otherwise add the delivered beat's clamped lanes and stick at all-ones.
    always_comb begin
        sum = {1'b0, sat_count_q};
        for (int i = 0; i < N; i++) sum = sum + (SAT_CNT_WIDTH + 1)'(sat_q[i] && s2_valid_q && data_out_0.ready);
        sat_count_d = sat_count_clr ? '0 : sum[SAT_CNT_WIDTH] ? '1 : sum[SAT_CNT_WIDTH-1:0];
    end

    // Saturation event counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sat_count_q <= '0;
        else sat_count_q <= sat_count_d;
    end
endmodule
